// File: rtl/y_serial_arith.sv
// Bit-serial adder/subtractor: one full-adder cell processes one bit per clock,
// LSB first. Results appear on z/cout/ovf only when an operation completes.
module y_serial_arith #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             ctrl,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] z,
   output logic             cout,
   output logic             ovf,
   output logic [1:0]       state_dbg
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic             load;
   logic             bits_done;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_sh, b_sh, acc;
   logic             carry, c_msb;
   logic             sum_bit, carry_nxt;

   // Handshake: start is honoured only in IDLE or DONE (load=1); while busy it
   // is ignored and a/b/ctrl are not sampled. done is a one-cycle pulse.
   assign bits_done = (cnt == CW'(WIDTH));
   assign sum_bit   = a_sh[0] ^ b_sh[0] ^ carry;
   assign carry_nxt = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
   assign state_dbg = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      load      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (bits_done) state_nxt = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               load      = 1'b1;
               state_nxt = RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh  <= '0;
         b_sh  <= '0;
         acc   <= '0;
         carry <= 1'b0;
         c_msb <= 1'b0;
         cnt   <= '0;
         z     <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else if (load) begin
         a_sh  <= a;
         b_sh  <= ctrl ? ~b : b;
         carry <= ctrl;
         cnt   <= '0;
         acc   <= '0;
      end else if (state == RUN) begin
         if (!bits_done) begin
            acc   <= {sum_bit, acc[WIDTH-1:1]};
            a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
            carry <= carry_nxt;
            cnt   <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) c_msb <= carry;
         end else begin
            // Publish the completed result on the transition into DONE.
            z    <= acc;
            cout <= carry;
            ovf  <= carry ^ c_msb;
         end
      end
   end

endmodule

// File: tb/tb_y_serial_arith.sv
// Directed bench for y_serial_arith: 32-bit vectors with hand-computed results
// and an exhaustive 4-bit sweep against a reference sum.
module tb_y_serial_arith;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0, ctrl = 1'b0;
   logic [31:0] a = '0, b = '0;
   logic        busy, done, cout, ovf;
   logic [31:0] z;
   logic [1:0]  state_dbg;

   logic        start4 = 1'b0, ctrl4 = 1'b0;
   logic [3:0]  a4 = '0, b4 = '0;
   logic        busy4, done4, cout4, ovf4;
   logic [3:0]  z4;
   logic [1:0]  state_dbg4;

   int          total = 0;
   int          bad = 0;
   logic [31:0] prev_z = '0;
   int          done_seen;

   always #5 clk = ~clk;

   y_serial_arith #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .ctrl(ctrl), .a(a), .b(b),
      .busy(busy), .done(done), .z(z), .cout(cout), .ovf(ovf), .state_dbg(state_dbg)
   );

   y_serial_arith #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .ctrl(ctrl4), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .z(z4), .cout(cout4), .ovf(ovf4), .state_dbg(state_dbg4)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one 32-bit op at a negedge. hold>0 keeps start high with random
   // operands for that many cycles of RUN. chain=1 returns in the DONE cycle.
   task automatic run_op(input string tag, input logic c, input logic [31:0] aa,
                         input logic [31:0] bb, input logic [31:0] ez, input logic ec,
                         input logic eo, input int hold, input bit chain);
      int lat;
      start = 1'b1; ctrl = c; a = aa; b = bb;
      @(negedge clk);
      lat = 0;
      chk({tag, " busy_after_start"}, {63'd0, busy}, 64'd1);
      while (done !== 1'b1 && lat < 100) begin
         if (lat < hold) begin
            start = 1'b1;
            a = $urandom; b = $urandom; ctrl = 1'($urandom_range(0, 1));
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         lat++;
         if (lat == 16) chk({tag, " z_hold_mid_run"}, {32'd0, z}, {32'd0, prev_z});
      end
      start = 1'b0;
      chk({tag, " latency"}, 64'(lat), 64'd33);
      chk({tag, " z"}, {32'd0, z}, {32'd0, ez});
      chk({tag, " cout"}, {63'd0, cout}, {63'd0, ec});
      chk({tag, " ovf"}, {63'd0, ovf}, {63'd0, eo});
      prev_z = ez;
      if (!chain) begin
         @(negedge clk);
         chk({tag, " done_one_cycle"}, {62'd0, done, busy}, 64'd0);
      end
   endtask

   task automatic run4(input logic c, input logic [3:0] aa, input logic [3:0] bb);
      int lat;
      logic [4:0] full;
      logic       eo;
      full = {1'b0, aa} + {1'b0, (c ? ~bb : bb)} + {4'd0, c};
      eo   = (aa[3] == (c ? ~bb[3] : bb[3])) && (full[3] != aa[3]);
      start4 = 1'b1; ctrl4 = c; a4 = aa; b4 = bb;
      @(negedge clk);
      start4 = 1'b0;
      lat = 0;
      while (done4 !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("w4 latency", 64'(lat), 64'd5);
      chk("w4 cout_z", {59'd0, cout4, z4}, {59'd0, full});
      chk("w4 ovf", {63'd0, ovf4}, {63'd0, eo});
   endtask

   initial begin
      #1;
      chk("reset busy", {63'd0, busy}, 64'd0);
      chk("reset done", {63'd0, done}, 64'd0);
      chk("reset z", {32'd0, z}, 64'd0);
      chk("reset cout_ovf", {62'd0, cout, ovf}, 64'd0);
      chk("reset state", {62'd0, state_dbg}, 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Start in the first edge after reset release is accepted.
      run_op("add5_3", 1'b0, 32'h5, 32'h3, 32'h8, 1'b0, 1'b0, 0, 1'b0);
      run_op("sub3_5", 1'b1, 32'h3, 32'h5, 32'hFFFFFFFE, 1'b0, 1'b0, 0, 1'b0);
      run_op("sub5_3", 1'b1, 32'h5, 32'h3, 32'h2, 1'b1, 1'b0, 0, 1'b0);
      run_op("add_maxpos", 1'b0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1'b1, 0, 1'b0);
      run_op("add_wrap", 1'b0, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b1, 1'b0, 0, 1'b0);
      run_op("start_held", 1'b0, 32'h0000FFFF, 32'h00010001, 32'h00020000, 1'b0, 1'b0, 20, 1'b0);
      run_op("b2b_first", 1'b0, 32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 1'b0, 0, 1'b1);
      run_op("b2b_second", 1'b1, 32'h10, 32'h10, 32'h0, 1'b1, 1'b0, 0, 1'b0);
      run_op("sub_minneg", 1'b1, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1'b1, 1'b1, 0, 1'b0);

      // Abort an operation around bit 10 with an asynchronous reset.
      start = 1'b1; ctrl = 1'b0; a = 32'hAAAA5555; b = 32'h1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort busy", {63'd0, busy}, 64'd0);
      chk("abort z", {32'd0, z}, 64'd0);
      chk("abort cout_ovf_done", {61'd0, cout, ovf, done}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      done_seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1) done_seen++;
      end
      chk("abort no_done", 64'(done_seen), 64'd0);
      prev_z = 32'h0;
      run_op("after_abort", 1'b0, 32'hAAAA5555, 32'h1, 32'hAAAA5556, 1'b0, 1'b0, 0, 1'b0);

      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      prev_z = 32'h0;
      run_op("start_at_release", 1'b1, 32'h1, 32'h2, 32'hFFFFFFFF, 1'b0, 1'b0, 0, 1'b0);

      for (int c = 0; c < 2; c++)
         for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
               run4(c[0], i[3:0], j[3:0]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/y_serial_arith.md
Y_SERIAL_ARITH -- requirements
Module: y_serial_arith

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand and result width in bits (legal range 2..64).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port start, input, 1, request to begin an operation; sampled on clk rising edge.
REQ-005 SHALL have port ctrl, input, 1, operation select: 0 = add (a+b), 1 = subtract (a-b); sampled with start.
REQ-006 SHALL have port a, input, WIDTH, first operand; sampled with start.
REQ-007 SHALL have port b, input, WIDTH, second operand; sampled with start.
REQ-008 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-009 SHALL have port done, output, 1, one-cycle pulse marking valid results.
REQ-010 SHALL have port z, output, WIDTH, sum or difference.
REQ-011 SHALL have port cout, output, 1, carry out of MSB (for subtract: 1 = no borrow, i.e. a >= b unsigned).
REQ-012 SHALL have port ovf, output, 1, two's-complement signed overflow.

Function
REQ-013 SHALL compute the result bit-serially, LSB first, through a single 1-bit full-adder cell (z_i = a_i^b'_i^c, c_next = majority), one bit per clk cycle.
REQ-014 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-015 IDLE: busy=0, done=0; on start=1, SHALL load operand shift registers with a and (ctrl ? ~b : b), carry register with ctrl, bit counter with 0, and go to RUN.
REQ-016 RUN: busy=1; each cycle SHALL shift one result bit into z register MSB-side, update carry, increment counter; after the WIDTH-th bit SHALL go to DONE.
REQ-017 DONE: busy=0, done=1 for exactly one cycle; SHALL go to IDLE, or directly to RUN if start=1 in that cycle (back-to-back, new operands loaded as in REQ-015).
REQ-018 Latency: start sampled at edge N SHALL yield done=1 and valid z/cout/ovf in the cycle following edge N+WIDTH+1.
REQ-019 start while busy=1 SHALL be ignored; operands and ctrl SHALL not be re-sampled.
REQ-020 z, cout, ovf SHALL hold their last completed values from DONE until the next operation completes; intermediate partial values SHALL NOT appear on z while busy (z updates only on entry to DONE).
REQ-021 cout SHALL equal the carry out of bit WIDTH-1; ovf SHALL equal carry-into-MSB XOR carry-out-of-MSB.
REQ-022 Arithmetic SHALL be modulo 2^WIDTH; wrap-around (e.g. max+1) SHALL produce z=0 with cout=1, no error state.
REQ-023 a, b, ctrl changes while busy SHALL NOT affect the in-flight result.

Reset
REQ-024 rst_n=0 SHALL immediately, without clk, force state IDLE, busy=0, done=0, z=0, cout=0, ovf=0, counter=0, carry=0.
REQ-025 Reset asserted mid-operation SHALL abort it; no done pulse SHALL follow; first start after rst_n rises SHALL behave as from power-up.
REQ-026 start=1 in the first edge after rst_n deassertion SHALL be accepted.

Verification (WIDTH=32 unless stated)
REQ-027 add a=0x00000005, b=0x00000003 -> done pulse exactly 33 cycles after start edge, z=0x00000008, cout=0, ovf=0.
REQ-028 sub a=0x00000003, b=0x00000005 -> z=0xFFFFFFFE, cout=0 (borrow), ovf=0; sub a=5,b=3 -> z=2, cout=1.
REQ-029 add a=0x7FFFFFFF, b=0x00000001 -> z=0x80000000, ovf=1, cout=0; add a=0xFFFFFFFF, b=1 -> z=0, cout=1, ovf=0.
REQ-030 start held high with changing operands during RUN -> ignored; start=1 during done cycle -> second result done exactly 32+1 cycles later, no idle gap.
REQ-031 rst_n pulsed low at bit 10 of an operation -> busy=0 and z=0 immediately, no done pulse; next operation correct.
REQ-032 WIDTH=4 exhaustive sweep, all a, b, ctrl (512 cases) -> {cout,z} and ovf match the reference-model arithmetic for every case.
